// File: rtl/fpu_host_if.sv
// rtl/fpu_host_if.sv - CPU-side register window and start/done/ack initiator for the FPU core
//
// Ports:
//   clk, arst        rising-edge clock, asynchronous active-low reset
//   cs, wr, rd       bus chip select and strobes (a write acts when cs&wr)
//   addr, din, dout  4-bit register address, 8-bit write/read data (dout is combinational)
//   irq              level interrupt: irq_en && (result_valid || any error)
//   fpu_operation    opcode to the core
//   fpu_a, fpu_b     operand registers to the core
//   fpu_start        start request, held until done or timeout
//   fpu_done         core completion flag
//   fpu_result       core result, valid while fpu_done=1
//   fpu_ack          result acknowledge, held until done falls
module fpu_host_if #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned OPCODE_MAX     = 10
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [3:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        irq,
  output logic [3:0]  fpu_operation,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_start,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  output logic        fpu_ack
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_ACK
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]      result_q;
  logic [CNT_W-1:0] tcnt;
  logic             result_valid;
  logic             illegal_op;
  logic             timeout_err;
  logic             overrun;
  logic             irq_en;

  logic wr_en;
  logic busy;
  logic wr_operand;
  logic wr_cmd;
  logic wr_ctrl;
  logic cmd_legal;
  logic cmd_accept;
  logic cmd_reject;
  logic done_take;
  logic tmo_hit;
  logic ack_release;

  assign wr_en       = cs & wr;
  assign busy        = (state != S_IDLE);
  assign wr_operand  = wr_en & ~addr[3];
  assign wr_cmd      = wr_en & (addr == 4'hC);
  assign wr_ctrl     = wr_en & (addr == 4'hE);
  assign cmd_legal   = (32'(din[3:0]) <= OPCODE_MAX);
  assign cmd_accept  = wr_cmd & ~busy & cmd_legal;
  assign cmd_reject  = wr_cmd & ~busy & ~cmd_legal;
  assign done_take   = (state == S_WAIT_DONE) & fpu_done;
  // Done wins over timeout when both land on the last allowed cycle.
  assign tmo_hit     = (state == S_WAIT_DONE) & ~fpu_done & (tcnt == CNT_LAST);
  assign ack_release = (state == S_ACK) & ~fpu_done;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fpu_start = 1'b0;
    fpu_ack   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_accept) state_nxt = S_START;
      end
      S_START: begin
        fpu_start = 1'b1;
        state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        fpu_start = 1'b1;
        if (done_take)    state_nxt = S_ACK;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_ACK: begin
        fpu_ack = 1'b1;
        if (ack_release) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      fpu_a         <= '0;
      fpu_b         <= '0;
      fpu_operation <= '0;
      result_q      <= '0;
      tcnt          <= '0;
      result_valid  <= 1'b0;
      illegal_op    <= 1'b0;
      timeout_err   <= 1'b0;
      overrun       <= 1'b0;
      irq_en        <= 1'b0;
    end else begin
      // Operands are frozen while the core owns them.
      if (wr_operand && !busy) begin
        if (addr[2]) fpu_b[{addr[1:0], 3'b000} +: 8] <= din;
        else         fpu_a[{addr[1:0], 3'b000} +: 8] <= din;
      end

      // The counter tracks cycles with fpu_start high, so the abort
      // lands after exactly TIMEOUT_CYCLES start cycles.
      if (cmd_accept) begin
        fpu_operation <= din[3:0];
        tcnt          <= '0;
      end else if (fpu_start) begin
        tcnt <= tcnt + 1'b1;
      end

      if (done_take) result_q <= fpu_result;

      // Clears are applied first so a same-cycle set overrides them.
      if (wr_ctrl) begin
        irq_en <= din[0];
        if (din[1]) begin
          result_valid <= 1'b0;
          illegal_op   <= 1'b0;
          timeout_err  <= 1'b0;
          overrun      <= 1'b0;
        end
      end
      if (cmd_accept) begin
        result_valid <= 1'b0;
        illegal_op   <= 1'b0;
        timeout_err  <= 1'b0;
      end
      if (cmd_reject)                      illegal_op   <= 1'b1;
      if (tmo_hit)                         timeout_err  <= 1'b1;
      if (ack_release)                     result_valid <= 1'b1;
      if (busy && (wr_operand || wr_cmd))  overrun      <= 1'b1;
    end
  end

  assign irq = irq_en & (result_valid | illegal_op | timeout_err | overrun);

  always_comb begin
    dout = 8'h00;
    if (cs && rd) begin
      case (addr[3:2])
        2'b00: dout = fpu_a[{addr[1:0], 3'b000} +: 8];
        2'b01: dout = fpu_b[{addr[1:0], 3'b000} +: 8];
        2'b10: dout = result_q[{addr[1:0], 3'b000} +: 8];
        default: begin
          case (addr[1:0])
            2'b00:   dout = {4'b0000, fpu_operation};
            2'b01:   dout = {3'b000, overrun, timeout_err, illegal_op, result_valid, busy};
            2'b10:   dout = {7'b0000000, irq_en};
            default: dout = 8'h00;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_host_if.sv
// tb/tb_fpu_host_if.sv - directed self-checking bench for fpu_host_if
module tb_fpu_host_if;

  logic        clk;
  logic        arst;
  logic        cs;
  logic        wr;
  logic        rd;
  logic [3:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        irq;
  logic [3:0]  fpu_operation;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_start;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic        fpu_ack;

  int checks;
  int errors;

  // core model controls
  bit          m_en;
  bit          m_sum;
  int          m_delay;
  int          m_hold;
  logic [31:0] m_res;
  int          m_cnt;
  int          m_hcnt;

  fpu_host_if #(
    .TIMEOUT_CYCLES(16),
    .OPCODE_MAX(10)
  ) dut (
    .clk(clk),
    .arst(arst),
    .cs(cs),
    .wr(wr),
    .rd(rd),
    .addr(addr),
    .din(din),
    .dout(dout),
    .irq(irq),
    .fpu_operation(fpu_operation),
    .fpu_a(fpu_a),
    .fpu_b(fpu_b),
    .fpu_start(fpu_start),
    .fpu_done(fpu_done),
    .fpu_result(fpu_result),
    .fpu_ack(fpu_ack)
  );

  always #5 clk = ~clk;

  // Core model: raises done after m_delay cycles of start, holds it for
  // m_hold cycles of ack, then drops it.
  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      fpu_done   <= 1'b0;
      fpu_result <= '0;
      m_cnt      <= 0;
      m_hcnt     <= 0;
    end else if (!fpu_done) begin
      m_hcnt <= 0;
      if (m_en && fpu_start) begin
        if (m_cnt == m_delay - 1) begin
          fpu_done   <= 1'b1;
          fpu_result <= m_sum ? (fpu_a + fpu_b) : m_res;
          m_cnt      <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else begin
        m_cnt <= 0;
      end
    end else if (fpu_ack) begin
      if (m_hcnt == m_hold - 1) begin
        fpu_done <= 1'b0;
        m_hcnt   <= 0;
      end else begin
        m_hcnt <= m_hcnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; din = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1;
    d = dout;
    tick();
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic write32(input logic [3:0] base, input logic [31:0] v);
    for (int i = 0; i < 4; i++) bus_write(base + 4'(i), v[8*i +: 8]);
  endtask

  task automatic read32(input logic [3:0] base, output logic [31:0] v);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      bus_read(base + 4'(i), b);
      v[8*i +: 8] = b;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while ((fpu_start || fpu_ack) && n < 200) begin
      tick();
      n++;
    end
    ok = !(fpu_start || fpu_ack);
  endtask

  task automatic test_reset();
    logic [7:0] s;
    arst = 1'b0;
    repeat (3) tick();
    arst = 1'b1;
    tick();
    if (fpu_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", fpu_start); end
    checks++;
    if (fpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", fpu_ack); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++;
    if ({fpu_a, fpu_b, fpu_operation} !== 68'h0) begin
      errors++; $display("FAIL reset_regs: got a=%h b=%h op=%h expected zeros", fpu_a, fpu_b, fpu_operation);
    end
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout_idle: got %h expected 00", dout); end
    checks++;
    bus_read(4'hD, s);
    if (s !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", s); end
    checks++;
    bus_read(4'hE, s);
    if (s !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h expected 00", s); end
    checks++;
  endtask

  task automatic test_add();
    logic [31:0] r;
    logic [7:0]  s;
    bit          ok;
    m_en = 1'b1; m_sum = 1'b0; m_delay = 5; m_hold = 2; m_res = 32'h4040_0000;
    bus_write(4'hE, 8'h01);
    write32(4'h0, 32'h3F80_0000);
    write32(4'h4, 32'h4000_0000);
    if (fpu_a !== 32'h3F80_0000) begin errors++; $display("FAIL add_fpu_a: got %h expected 3f800000", fpu_a); end
    checks++;
    if (fpu_b !== 32'h4000_0000) begin errors++; $display("FAIL add_fpu_b: got %h expected 40000000", fpu_b); end
    checks++;
    if (fpu_start !== 1'b0) begin errors++; $display("FAIL add_start_before: got %b expected 0", fpu_start); end
    checks++;
    bus_write(4'hC, 8'h00);
    if (fpu_start !== 1'b1) begin errors++; $display("FAIL add_start_latency: got %b expected 1", fpu_start); end
    checks++;
    wait_idle(ok);
    if (ok !== 1'b1) begin errors++; $display("FAIL add_complete: got %b expected 1", ok); end
    checks++;
    read32(4'h8, r);
    if (r !== 32'h4040_0000) begin errors++; $display("FAIL add_result: got %h expected 40400000", r); end
    checks++;
    bus_read(4'hD, s);
    if (s !== 8'h02) begin errors++; $display("FAIL add_status: got %h expected 02", s); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL add_irq: got %b expected 1", irq); end
    checks++;
  endtask

  task automatic test_illegal();
    logic [7:0] s;
    bit         seen;
    bus_write(4'hE, 8'h03);
    bus_read(4'hD, s);
    if (s !== 8'h00) begin errors++; $display("FAIL ill_preclear: got %h expected 00", s); end
    checks++;
    bus_write(4'hC, 8'h0F);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (fpu_start) seen = 1'b1;
      tick();
    end
    if (seen !== 1'b0) begin errors++; $display("FAIL ill_no_start: got %b expected 0", seen); end
    checks++;
    bus_read(4'hD, s);
    if (s !== 8'h04) begin errors++; $display("FAIL ill_status: got %h expected 04", s); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ill_irq: got %b expected 1", irq); end
    checks++;
    bus_write(4'hE, 8'h03);
    bus_read(4'hD, s);
    if (s !== 8'h00) begin errors++; $display("FAIL ill_clear: got %h expected 00", s); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ill_irq_clear: got %b expected 0", irq); end
    checks++;
  endtask

  task automatic test_timeout();
    logic [31:0] r;
    logic [7:0]  s;
    int          n;
    m_en = 1'b0;
    bus_write(4'hE, 8'h00);
    bus_write(4'hC, 8'h01);
    n = 0;
    while (fpu_start && n < 100) begin
      n++;
      tick();
    end
    if (n !== 16) begin errors++; $display("FAIL tmo_start_cycles: got %0d expected 16", n); end
    checks++;
    bus_read(4'hD, s);
    if (s !== 8'h08) begin errors++; $display("FAIL tmo_status: got %h expected 08", s); end
    checks++;
    read32(4'h8, r);
    if (r !== 32'h4040_0000) begin errors++; $display("FAIL tmo_result_kept: got %h expected 40400000", r); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL tmo_irq_masked: got %b expected 0", irq); end
    checks++;
    bus_write(4'hE, 8'h01);
    if (irq !== 1'b1) begin errors++; $display("FAIL tmo_irq_enabled: got %b expected 1", irq); end
    checks++;
    bus_write(4'hE, 8'h02);
    bus_read(4'hD, s);
    if (s !== 8'h00 || irq !== 1'b0) begin
      errors++; $display("FAIL tmo_clear: got status=%h irq=%b expected 00/0", s, irq);
    end
    checks++;
  endtask

  task automatic test_busy_write();
    logic [31:0] r;
    logic [7:0]  s;
    bit          ok;
    m_en = 1'b1; m_sum = 1'b1; m_delay = 8; m_hold = 1;
    write32(4'h0, 32'h0100_0000);
    write32(4'h4, 32'h0200_0000);
    bus_write(4'hC, 8'h02);
    write32(4'h0, 32'h1122_3344);
    bus_write(4'hC, 8'h07);
    if (fpu_a !== 32'h0100_0000) begin errors++; $display("FAIL busy_fpu_a: got %h expected 01000000", fpu_a); end
    checks++;
    if (fpu_operation !== 4'h2) begin errors++; $display("FAIL busy_opcode: got %h expected 2", fpu_operation); end
    checks++;
    bus_read(4'hD, s);
    if (s !== 8'h11) begin errors++; $display("FAIL busy_status: got %h expected 11", s); end
    checks++;
    wait_idle(ok);
    if (ok !== 1'b1) begin errors++; $display("FAIL busy_complete: got %b expected 1", ok); end
    checks++;
    read32(4'h8, r);
    if (r !== 32'h0300_0000) begin errors++; $display("FAIL busy_result: got %h expected 03000000", r); end
    checks++;
    bus_read(4'hD, s);
    if (s !== 8'h12) begin errors++; $display("FAIL busy_status_done: got %h expected 12", s); end
    checks++;
    bus_write(4'hE, 8'h02);
    bus_read(4'hD, s);
    if (s !== 8'h00) begin errors++; $display("FAIL busy_clear: got %h expected 00", s); end
    checks++;
  endtask

  task automatic test_ack_handshake();
    logic [31:0] r;
    bit          early;
    int          n;
    m_en = 1'b1; m_sum = 1'b0; m_delay = 3; m_hold = 10; m_res = 32'h1234_5678;
    bus_write(4'hE, 8'h01);
    bus_write(4'hC, 8'h03);
    n = 0;
    while (!fpu_ack && n < 50) begin
      tick();
      n++;
    end
    if (fpu_ack !== 1'b1) begin errors++; $display("FAIL ack_seen: got %b expected 1", fpu_ack); end
    checks++;
    cs = 1'b1; rd = 1'b1; addr = 4'hD;
    early = 1'b0;
    n = 0;
    while (fpu_ack && n < 100) begin
      if (dout[1]) early = 1'b1;
      n++;
      tick();
    end
    if (n !== 11) begin errors++; $display("FAIL ack_cycles: got %0d expected 11", n); end
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL ack_valid_early: got %b expected 0", early); end
    checks++;
    if (dout !== 8'h02) begin errors++; $display("FAIL ack_status: got %h expected 02", dout); end
    checks++;
    cs = 1'b0; rd = 1'b0;
    if (irq !== 1'b1) begin errors++; $display("FAIL ack_irq: got %b expected 1", irq); end
    checks++;
    read32(4'h8, r);
    if (r !== 32'h1234_5678) begin errors++; $display("FAIL ack_result: got %h expected 12345678", r); end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [7:0]  s;
    bit          ok;
    m_en = 1'b1; m_sum = 1'b1; m_delay = 20; m_hold = 1;
    bus_write(4'hC, 8'h04);
    repeat (3) tick();
    if (fpu_start !== 1'b1) begin errors++; $display("FAIL mid_in_wait: got %b expected 1", fpu_start); end
    checks++;
    #2;
    arst = 1'b0;
    #1;
    if ({fpu_start, fpu_ack, irq} !== 3'b000) begin
      errors++; $display("FAIL mid_async_outputs: got start/ack/irq=%b expected 000", {fpu_start, fpu_ack, irq});
    end
    checks++;
    cs = 1'b1; rd = 1'b1; addr = 4'hD;
    #1;
    if (dout !== 8'h00) begin errors++; $display("FAIL mid_status: got %h expected 00", dout); end
    checks++;
    cs = 1'b0; rd = 1'b0;
    tick();
    arst = 1'b1;
    tick();
    m_delay = 4;
    write32(4'h0, 32'h0000_0005);
    write32(4'h4, 32'h0000_0007);
    bus_write(4'hE, 8'h01);
    bus_write(4'hC, 8'h0A);
    if (fpu_start !== 1'b1) begin errors++; $display("FAIL mid_max_opcode_start: got %b expected 1", fpu_start); end
    checks++;
    wait_idle(ok);
    if (ok !== 1'b1) begin errors++; $display("FAIL mid_complete: got %b expected 1", ok); end
    checks++;
    read32(4'h8, r);
    if (r !== 32'h0000_000C) begin errors++; $display("FAIL mid_result: got %h expected 0000000c", r); end
    checks++;
    bus_read(4'hD, s);
    if (s !== 8'h02 || irq !== 1'b1) begin
      errors++; $display("FAIL mid_status_done: got status=%h irq=%b expected 02/1", s, irq);
    end
    checks++;
    bus_read(4'hC, s);
    if (s !== 8'h0A) begin errors++; $display("FAIL mid_opcode_read: got %h expected 0a", s); end
    checks++;
  endtask

  task automatic test_rw_same_cycle();
    logic [7:0] s;
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 4'h0; din = 8'hAA;
    #1;
    if (dout !== 8'h05) begin errors++; $display("FAIL rw_pre_write_data: got %h expected 05", dout); end
    checks++;
    tick();
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    bus_read(4'h0, s);
    if (s !== 8'hAA) begin errors++; $display("FAIL rw_write_taken: got %h expected aa", s); end
    checks++;
    bus_write(4'hF, 8'hFF);
    bus_read(4'hF, s);
    if (s !== 8'h00) begin errors++; $display("FAIL reserved_read: got %h expected 00", s); end
    checks++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; arst = 1'b0;
    cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 4'h0; din = 8'h00;
    m_en = 1'b0; m_sum = 1'b0; m_delay = 1; m_hold = 1; m_res = '0;
    checks = 0; errors = 0;
    #1;
    test_reset();
    test_add();
    test_illegal();
    test_timeout();
    test_busy_write();
    test_ack_handshake();
    test_reset_mid();
    test_rw_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_host_if.md
Name: fpu_host_if

Overview:
- CPU-side initiator for the FPU core. It is the opposite end of the core's start / wait / finish / wait-ack handshake.
- Presents an 8-bit register window to the Sol-1 bus.
- Assembles 32-bit operands A and B byte by byte, issues an opcode, runs the start/done/ack handshake, latches the 32-bit result and raises an optional interrupt.

Parameters:
- TIMEOUT_CYCLES, 4096: cycles allowed in WAIT_DONE before the operation is aborted.
- OPCODE_MAX, 10: highest legal opcode (op_exp). Any larger opcode is rejected without starting the core.

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  asynchronous, active-low reset.
- cs  in  1  chip select.
- wr  in  1  write strobe; acts for one cycle when cs=1.
- rd  in  1  read strobe.
- addr  in  4  register address.
- din  in  8  write data.
- dout  out  8  read data; combinational; 0 when not (cs&&rd).
- irq  out  1  interrupt; level output = irq_en && (result_valid || err).
- fpu_operation  out  4  opcode to the core; held stable while busy.
- fpu_a  out  32  operand A register.
- fpu_b  out  32  operand B register.
- fpu_start  out  1  start request to the core.
- fpu_done  in  1  core completion flag.
- fpu_result  in  32  core result; valid while fpu_done=1.
- fpu_ack  out  1  result acknowledge to the core.

Behaviour:
- Reset (arst=0, asynchronous), all registers cleared:
  - A, B, result, opcode = 0.
  - fpu_start = 0, fpu_ack = 0, irq = 0.
  - Status = 0, irq_en = 0, timeout counter = 0, state = IDLE.
- Register map (little-endian byte order):
  - 0-3: A[7:0]..A[31:24], read/write.
  - 4-7: B bytes, read/write.
  - 8-B: result bytes, read-only.
  - C: command, write {opcode in bits 3:0}; reads back the opcode.
  - D: status, read-only:
    - bit0 busy
    - bit1 result_valid
    - bit2 illegal_op
    - bit3 timeout
    - bit4 overrun
  - E: control. Write: bit0 irq_en; bit1 = 1 clears status bits 1-4 (self-clearing). Reads return {7'b0, irq_en}.
  - F: reserved; reads 0, writes ignored.
- FSM states and transitions:
  - IDLE:
    - A write to C with opcode <= OPCODE_MAX latches the opcode, clears result_valid/illegal_op/timeout, and moves to START.
    - If the opcode is > OPCODE_MAX: set illegal_op, stay in IDLE, fpu_start stays 0.
  - START: fpu_start=1 from the cycle after the command write. Go to WAIT_DONE next cycle.
  - WAIT_DONE:
    - fpu_start is held at 1 until fpu_done=1 is sampled.
    - On fpu_done=1: latch fpu_result, drop fpu_start, assert fpu_ack, go to ACK.
    - The counter increments each cycle. When it reaches TIMEOUT_CYCLES-1: drop fpu_start, set timeout, go to IDLE. The result is unchanged.
  - ACK: hold fpu_ack=1 until fpu_done=0 is sampled. Then drop fpu_ack, set result_valid, go to IDLE.
  - busy = (state != IDLE).
- Latency:
  - Command write in cycle N → fpu_start high in cycle N+1.
  - fpu_done first sampled high in cycle M → result register and fpu_ack updated at M+1.
  - fpu_done sampled low in cycle K → result_valid=1 and busy=0 at K+1.
- Writes while busy:
  - Writes to 0-7 and C are ignored and set overrun. Operands and opcode stay stable on the fpu_* outputs.
  - Writes to E are always accepted.
- Simultaneous events:
  - A clear write on E in the same cycle that result_valid, timeout, illegal_op or overrun is set: the set wins.
  - rd and wr in the same cycle: the write takes effect; dout shows pre-write data.
- fpu_done=1 already high while in IDLE: ignored, no state change.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The core is expected to be reset by the same arst.

Test Plan:
- Add 1.0+2.0:
  - Stimulus: write A=0x3F800000, B=0x40000000, C=0x0. The core model answers 0x40400000 after 5 cycles and drops done 2 cycles after ack.
  - Required: fpu_start rises 1 cycle after the write; bytes at addr 8..B = 00 00 40 40; status=0x02; irq=1 with irq_en=1.
- Illegal opcode:
  - Stimulus: write C=0x0F.
  - Required: status=0x04, fpu_start never asserted, busy=0; then E=0x02 → status=0x00.
- Timeout, TIMEOUT_CYCLES=16:
  - Stimulus: model never asserts done.
  - Required: fpu_start high for exactly 16 cycles; status=0x08; result unchanged; irq follows irq_en.
- Writes while busy:
  - Stimulus: A=0x11223344 while WAIT_DONE.
  - Required: fpu_a unchanged, overrun set; the completed result still reflects the original operands; clear via E.
- Ack handshake:
  - Stimulus: model holds done for 10 cycles after ack.
  - Required: fpu_ack high for exactly those cycles plus 1; result_valid is set only after done falls.
- Reset mid-operation:
  - Stimulus: assert arst during WAIT_DONE.
  - Required: fpu_start/fpu_ack/irq=0 asynchronously and status=0x00; a new command after release completes normally.
